// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch block:
//                FSM state encoding, prefetch buffer entry layout, instruction
//                size and the end-of-program marker word.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch controller state; explicit one-bit encoding.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    // One prefetch buffer entry: the word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;
    localparam logic [31:0] END_INST   = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : Synchronous prefetch FIFO with push, pop and flush.
//                Head entry is read combinationally from storage, so a word
//                pushed into an empty buffer is visible the following cycle.
//                Flush (and rst) empties the buffer and wins over push/pop.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_push, i_data    - write request and entry
//                i_pop             - remove head entry
//                i_flush           - discard all contents
//                o_head            - current head entry (don't-care if empty)
//                o_count           - number of valid entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);

    // A push at full is only legal together with a pop; the slot being
    // written is the one the head vacates at the same edge.
    assign w_pop  = i_pop && !w_empty && !i_flush;
    assign w_push = i_push && (!w_full || w_pop) && !i_flush;

    // Pointers are c_ptr_w bits wide and DEPTH is a power of two, so the
    // natural binary overflow gives modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_buf
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. Walks a PC through a
//                combinational-read instruction memory, fills a small
//                prefetch buffer, stops at end-of-program (PC past memory or
//                an all-zero word) and restarts on a redirect.
//  Optional    : define FETCH_STATS_EN to add the saturating fetch_count port.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                imem_addr / imem_inst - instruction memory read port
//                redirect_valid/_pc    - branch/jump request and target
//                out_valid/ready       - head handshake towards decode
//                out_inst / out_pc     - head entry
//                halted                - fetch stopped at end-of-program
//                fetch_count           - words pushed since reset (optional)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          MEM_BYTES = 128,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int          c_cnt_w     = $clog2(BUF_DEPTH) + 1;
    localparam logic [31:0] c_mem_bytes = 32'(MEM_BYTES);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         w_fetch_pc_nxt;

    logic [c_cnt_w-1:0]  w_buf_count;
    fetch_entry_t        w_head;
    fetch_entry_t        w_push_data;
    logic                w_pop;
    logic                w_push;
    logic                w_flush;
    logic                w_want_fetch;
    logic                w_end;
    logic [1:0]          w_unused_redirect_lsb;

    // Redirect targets are word aligned; the low bits are dropped.
    assign w_unused_redirect_lsb = redirect_pc[1:0];

    assign out_valid = (w_buf_count != '0);
    assign w_pop     = out_valid && out_ready;

    // A slot is available if the buffer has room now or the head leaves
    // at this edge.
    assign w_want_fetch = (r_state == FETCH) &&
                          ((w_buf_count < c_cnt_w'(BUF_DEPTH)) || w_pop);

    assign w_end = (r_fetch_pc >= c_mem_bytes) || (imem_inst == END_INST);

    assign w_push_data.pc   = r_fetch_pc;
    assign w_push_data.inst = imem_inst;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, next PC and buffer controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;

        if (redirect_valid) begin
            // The head pop still happens (decode saw it), but everything
            // buffered and the fetch in flight this cycle belong to the old
            // path and are dropped.
            w_flush        = 1'b1;
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
            w_state_nxt    = FETCH;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (w_want_fetch) begin
                        if (w_end) begin
                            w_state_nxt = HALT;
                        end else begin
                            w_push         = 1'b1;
                            w_fetch_pc_nxt = r_fetch_pc + INST_BYTES;
                        end
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    fetch_buf #(
        .DEPTH   (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_buf_count)
    );

    assign imem_addr = r_fetch_pc;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign halted    = (r_state == HALT);

`ifdef FETCH_STATS_EN
    // Counts accepted pushes, including words later discarded by a flush.
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_push && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a 128-byte
//                instruction memory model. Expected head entries are queued
//                by the stimulus; a forked monitor pops and compares them on
//                every accepted head. Build with FETCH_STATS_EN to also
//                check fetch_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] mem [32];
    logic [63:0] sb_q [$];
    int          n_cmp;
    int          n_bad;

    assign imem_inst = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'h0;

    fetch_ctrl #(
        .MEM_BYTES      (128),
        .RESET_PC       (32'h0),
        .BUF_DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc);
        sb_q.push_back({pc, mem[pc[6:2]]});
    endtask

    task automatic monitor_loop();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no entry", out_pc, out_inst);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", out_pc, e[63:32]);
                    chk("sb_inst", out_inst, e[31:0]);
                end
            end
        end
    endtask

    task automatic wait_halt(input int budget, input string name);
        for (int i = 0; i < budget && halted !== 1'b1; i++) begin
            step();
        end
        chk(name, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        fork
            monitor_loop();
        join_none

        // ---------------- reset state + scenario 1 ----------------
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_0013;
        mem[2] = 32'h0000_0013;
        mem[3] = 32'h0000_0000;
        step();
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        expect_entry(32'h0);
        expect_entry(32'h4);
        expect_entry(32'h8);
        out_ready = 1'b1;
        rst       = 1'b0;
        step();
        chk("s1_c1_pc", out_pc, 32'h0);
        step();
        chk("s1_c2_pc", out_pc, 32'h4);
        step();
        chk("s1_c3_pc", out_pc, 32'h8);
        step();
        chk("s1_halted", {31'b0, halted}, 32'd1);
        chk("s1_out_valid", {31'b0, out_valid}, 32'd0);
        chk("s1_imem_addr", imem_addr, 32'hC);
        chk("s1_sb_left", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_STATS_EN
        chk("s1_fetch_count", fetch_count, 32'd3);
`endif

        // ---------------- scenario 2: backpressure ----------------
        rst       = 1'b1;
        out_ready = 1'b0;
        mem[0]    = 32'h0010_0013;
        mem[1]    = 32'h0020_0013;
        mem[2]    = 32'h0030_0013;
        step();
        expect_entry(32'h0);
        expect_entry(32'h4);
        expect_entry(32'h8);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("s2_hold_addr", imem_addr, 32'h8);
        chk("s2_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("s2_hold_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("s2_halted", {31'b0, halted}, 32'd1);
        chk("s2_sb_left", 32'(sb_q.size()), 32'd0);

        // ---------------- scenario 3/4: redirect, run to memory end ----------------
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 + (i << 20) + 32'h100;
        step();
        expect_entry(32'h0);
        expect_entry(32'h4);
        for (int a = 32; a < 128; a += 4) expect_entry(32'(a));
        rst = 1'b0;
        step();
        step();
        chk("s3_head_pc", out_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        step();
        redirect_valid = 1'b0;
        chk("s3_gap_valid", {31'b0, out_valid}, 32'd0);
        chk("s3_gap_addr", imem_addr, 32'h20);
        step();
        chk("s3_tgt_valid", {31'b0, out_valid}, 32'd1);
        chk("s3_tgt_pc", out_pc, 32'h20);
        wait_halt(100, "s4_halted");
        chk("s4_imem_addr", imem_addr, 32'd128);
        step();
        step();
        chk("s4_out_valid", {31'b0, out_valid}, 32'd0);
        chk("s4_sb_left", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_STATS_EN
        chk("s4_fetch_count", fetch_count, 32'd26);
`endif

        // ---------------- scenario 5: leave HALT, then reset mid-stream ----------------
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("s5_unhalt", {31'b0, halted}, 32'd0);
        chk("s5_gap_valid", {31'b0, out_valid}, 32'd0);
        step();
        step();
        chk("s5_head_valid", {31'b0, out_valid}, 32'd1);
        chk("s5_head_pc", out_pc, 32'h0);
        chk("s5_full_addr", imem_addr, 32'h8);
        mem[3]         = 32'h0;
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("s5_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("s5_rst_addr", imem_addr, 32'h0);
        redirect_valid = 1'b0;
        expect_entry(32'h0);
        expect_entry(32'h4);
        expect_entry(32'h8);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("s5_restart_pc", out_pc, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("s5_halted", {31'b0, halted}, 32'd1);
        chk("s5_sb_left", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_STATS_EN
        chk("s5_fetch_count", fetch_count, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MEM_BYTES, 128, instruction memory size in bytes.
  RESET_PC, 32'h0, PC loaded on reset.
  BUF_DEPTH, 2, prefetch buffer entries (power of 2, >=2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state changes on rising edge.
  rst  in  1  synchronous, active-high reset.
  imem_addr  out  32  byte address to instruction memory (combinational read, big-endian word).
  imem_inst  in  32  word returned for imem_addr; 0 when out of range.
  redirect_valid  in  1  branch/jump request this cycle.
  redirect_pc  in  32  new fetch PC.
  out_valid  out  1  buffer head valid.
  out_ready  in  1  decode accepts head.
  out_inst  out  32  head instruction.
  out_pc  out  32  head PC.
  halted  out  1  fetch stopped at end-of-program.
  fetch_count  out  32  words pushed since reset (FETCH_STATS_EN only).

Function
REQ-003 fetch_pc SHALL drive imem_addr directly; imem_addr changes only at clock edges.
REQ-004 States SHALL be FETCH and HALT; reset enters FETCH.
REQ-005 In FETCH, a fetch SHALL occur when count<BUF_DEPTH or a pop occurs this cycle; it pushes {fetch_pc, imem_inst} and advances fetch_pc by 4.
REQ-006 End-of-program: if fetch_pc>=MEM_BYTES or imem_inst==0 during a would-be fetch, nothing SHALL be pushed, fetch_pc holds, state -> HALT.
REQ-007 In HALT, no fetch SHALL occur; buffered entries keep draining; halted=1.
REQ-008 Pop SHALL occur when out_valid && out_ready; out_valid = (count!=0).
REQ-009 Latency: a word fetched in cycle N SHALL be visible at the head in cycle N+1 if the buffer was empty.
REQ-010 Buffer full and no pop: fetch stalls, fetch_pc holds, no entry lost or duplicated.
REQ-011 Simultaneous push and pop at full SHALL keep count unchanged, preserving order.
REQ-012 redirect_valid SHALL take priority: at the edge, pop is honoured, then the buffer is flushed (count=0), same-cycle fetch discarded, fetch_pc <= {redirect_pc[31:2],2'b00}, state -> FETCH.
REQ-013 Cycle after redirect: out_valid=0; the next cycle presents the redirect target (if not end-of-program).
REQ-014 fetch_pc SHALL wrap modulo 2^32; pointers SHALL wrap modulo BUF_DEPTH.

Reset
REQ-015 With rst=1 at an edge: fetch_pc=RESET_PC, count=0, pointers=0, state=FETCH, out_valid=0, halted=0, fetch_count=0.
REQ-016 rst SHALL override redirect and pop in the same cycle and flush any in-progress contents.
REQ-017 out_inst/out_pc SHALL be don't-care while out_valid=0.

Configuration
REQ-018 Macro FETCH_STATS_EN defined: fetch_count port present, increments by 1 per push, saturates at 32'hFFFF_FFFF.
REQ-019 Macro undefined: fetch_count port and counter absent; all other behaviour identical.

Structure
REQ-020 Shared package fetch_pkg SHALL hold the state enum (FETCH, HALT), a fetch_entry_t {pc[31:0], inst[31:0]}, and constants INST_BYTES=4 and END_INST=32'h0.
REQ-021 The prefetch buffer SHALL be one sub-module, fetch_buf (sync FIFO with push/pop/flush, count).

Verification
REQ-022 Bench SHALL use a 128-byte memory model and cover:
  Reset, words 0x00000013 at 0,4,8, zero at 12, out_ready=1 -> pcs 0,4,8 on consecutive cycles from cycle 1; halted=1 after pc 12 seen.
  out_ready=0 for 5 cycles -> count=2, imem_addr holds 8; release -> 0,4,8 in order, no duplicates.
  Redirect to 0x22 while head pc=4 with out_ready=1 -> pc 4 consumed, next cycle out_valid=0, then out_pc=0x20.
  Program with no zero word -> last word pc=124, halted=1, imem_addr=128, nothing pushed past 124.
  In HALT, redirect to 0 -> halted=0, fetch resumes at 0; rst asserted mid-stream -> out_valid=0 next cycle, restart at RESET_PC.
  FETCH_STATS_EN build: scenario 1 -> fetch_count=3; redirect-flushed words still counted.
